// File: rtl/cache_rbus_arbiter_if.sv
// Purpose: cache read-bus handshake (rrdy/ren/raddr/rvalid/rdata) shared by both caches and memory.
// Ports: master issues ren/raddr and receives rrdy/rvalid/rdata; slave is the responding side.
// Latency/backpressure: no logic here; rrdy gates acceptance of a new ren request.
interface cache_rbus_arbiter_if #(
  parameter int BLK_SIZE = 128
);
  logic                rrdy;
  logic [3:0]          ren;
  logic [31:0]         raddr;
  logic                rvalid;
  logic [BLK_SIZE-1:0] rdata;

  modport master (
    input  rrdy,
    input  rvalid,
    input  rdata,
    output ren,
    output raddr
  );

  modport slave (
    output rrdy,
    output rvalid,
    output rdata,
    input  ren,
    input  raddr
  );
endinterface

// File: rtl/cache_rbus_arbiter.sv
// Purpose: shares one memory read bus between ICache (p0) and DCache (p1), one slot per port, round-robin.
// Latency: request to mem_ren is 2 cycles; mem_rvalid to pN_rvalid is 1 cycle; one transaction in flight.
// Backpressure: pN_rrdy is low while the port's slot is full; grants wait for mem.rrdy in IDLE.
// Ports: cpu_clk, cpu_rst (async, active-high); p0/p1 slave bus from the caches; mem master bus to memory.
module cache_rbus_arbiter #(
  parameter int BLK_SIZE = 128
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  cache_rbus_arbiter_if.slave  p0,
  cache_rbus_arbiter_if.slave  p1,
  cache_rbus_arbiter_if.master mem
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t              state, state_nxt;
  logic [1:0]          pend;
  logic [3:0]          slot_ren  [2];
  logic [31:0]         slot_addr [2];
  logic                last;
  logic                owner;
  logic [3:0]          mem_ren_q;
  logic [31:0]         mem_raddr_q;
  logic [1:0]          rvalid_q;
  logic [BLK_SIZE-1:0] rdata_q   [2];

  logic [3:0]          ren_in    [2];
  logic [31:0]         addr_in   [2];
  logic                grant;
  logic                ret;
  logic                win;

  assign ren_in[0]  = p0.ren;
  assign ren_in[1]  = p1.ren;
  assign addr_in[0] = p0.raddr;
  assign addr_in[1] = p1.raddr;

  // Lone pending port wins outright; on a tie the port that was not granted last wins.
  assign win = (pend == 2'b11) ? ~last : ~pend[0];

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    ret       = 1'b0;
    case (state)
      IDLE: begin
        if ((|pend) && mem.rrdy) begin
          grant     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (mem.rvalid) begin
          ret       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      pend        <= '0;
      last        <= 1'b1;
      owner       <= 1'b0;
      mem_ren_q   <= '0;
      mem_raddr_q <= 32'hFFFF_FFFF;
      rvalid_q    <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_ren[i]  <= '0;
        slot_addr[i] <= '0;
        rdata_q[i]   <= '0;
      end
    end else begin
      // mem_ren and rvalid are single-cycle pulses; raddr and rdata hold.
      mem_ren_q <= '0;
      rvalid_q  <= '0;
      if (grant) begin
        mem_ren_q   <= slot_ren[win];
        mem_raddr_q <= slot_addr[win];
        owner       <= win;
        last        <= win;
      end
      if (ret) begin
        rvalid_q[owner] <= 1'b1;
        rdata_q[owner]  <= mem.rdata;
        pend[owner]     <= 1'b0;
      end
      // The owner's slot is still full here, so a capture never collides with the clear above.
      for (int i = 0; i < 2; i++) begin
        if ((ren_in[i] != 4'd0) && !pend[i]) begin
          pend[i]      <= 1'b1;
          slot_ren[i]  <= ren_in[i];
          slot_addr[i] <= addr_in[i];
        end
      end
    end
  end

  assign p0.rrdy   = ~pend[0];
  assign p1.rrdy   = ~pend[1];
  assign p0.rvalid = rvalid_q[0];
  assign p1.rvalid = rvalid_q[1];
  assign p0.rdata  = rdata_q[0];
  assign p1.rdata  = rdata_q[1];
  assign mem.ren   = mem_ren_q;
  assign mem.raddr = mem_raddr_q;

endmodule

// File: doc/cache_rbus_arbiter.md
# cache_rbus_arbiter

Arbitrates the single memory read bus between the ICache (port 0) and the DCache (port 1) refill engines. Each cache keeps its existing read-bus handshake (rrdy / ren / raddr / rvalid / rdata), and the arbiter presents that same handshake to both caches. It buffers one outstanding request per port, issues requests to memory one at a time in round-robin order, and routes each returned block to the port that requested it. The block sits between the two caches and the memory-side read interface.

## Interface
- BLK_SIZE, 128, refill block width in bits (4 words)
- cpu_clk  in  1  clock
- cpu_rst  in  1  reset, asynchronous, active-high; clock cpu_clk
- p0_rrdy  out  1  port 0 may issue a request (ICache side)
- p0_ren  in  4  port 0 read enable; a nonzero value is a request
- p0_raddr  in  32  port 0 block address
- p0_rvalid  out  1  port 0 data valid, one-cycle pulse
- p0_rdata  out  BLK_SIZE  port 0 returned block
- p1_rrdy, p1_ren, p1_raddr, p1_rvalid, p1_rdata: same as port 0, for the DCache
- mem_rrdy  in  1  memory accepts a read request
- mem_ren  out  4  memory read enable, one-cycle pulse
- mem_raddr  out  32  memory read address
- mem_rvalid  in  1  memory data valid
- mem_rdata  in  BLK_SIZE  memory read data

## Operation
- Each port has a pending slot holding a valid bit, the ren value and the address.
  - pN_rrdy = !pendN (combinational).
  - When pN_ren != 0 and pN_rrdy = 1 at a clock edge, the slot captures ren and raddr and the valid bit is set.
  - When pN_rrdy = 0, pN_ren is ignored and no second request is queued.
- Priority register `last` (0/1) holds the last port granted. Reset value: 1, so port 0 wins the first tie.
- States:
  - IDLE: if any slot is pending and mem_rrdy = 1, select the winner and move to WAIT.
    - Winner is the only pending port, or, when both are pending, the port != last.
    - At the same edge, register mem_ren = winner ren, mem_raddr = winner addr, owner = winner, last = winner.
    - With nothing pending, or mem_rrdy = 0, stay in IDLE.
  - WAIT: mem_ren = 0 from the second WAIT cycle onward.
    - On mem_rvalid = 1, register pOwner_rdata = mem_rdata and pOwner_rvalid = 1, clear the owner's slot, and move to IDLE.
- mem_ren is a single-cycle pulse per transaction, and only one transaction is outstanding at a time.
- mem_rvalid seen in IDLE is ignored. No output changes.
- A port may capture a new request while the other port's transaction is in WAIT. The owner's own slot stays full until its data returns, so it cannot queue a second request.
- Reset values:
  - state = IDLE, both slots empty, last = 1.
  - mem_ren = 0, mem_raddr = 32'hFFFFFFFF.
  - p0_rvalid = p1_rvalid = 0, p0_rdata = p1_rdata = 0.
- Reset mid-transaction drops every pending and in-flight request. A late mem_rvalid that follows reset is ignored.
- pN_rdata holds its value between transactions. pN_rvalid is 1 only in the single cycle after capture.

## Timing
- Cycle T: request pulse with rrdy = 1. The slot is valid from T+1, and pN_rrdy drops in T+1.
- Cycle T+1, with mem_rrdy = 1: the grant edge. mem_ren is nonzero during T+2 only.
- Memory returns mem_rvalid in cycle R, so pN_rvalid is high and pN_rdata is valid in R+1.
- Minimum request-to-data latency is 2 cycles plus memory latency plus 1.
- The next grant can issue at the edge ending R+1, giving a back-to-back mem_ren pulse in R+2.
- pN_rrdy rises in R+1, and the port may issue its next request in R+1.
- Simultaneous requests from both ports in the same cycle: both are captured, and the grant order follows `last`.

## Test plan
- Single ICache request:
  - Stimulus: p0_ren = 4'hF, raddr = 32'h0000_1230; memory returns 128'hA after 3 cycles.
  - Required: mem_ren pulses once with mem_raddr = 32'h0000_1230; p0_rvalid pulses once with p0_rdata = 128'hA; p1_rvalid stays 0.
- Simultaneous requests after reset:
  - Stimulus: p0 at 32'h100 and p1 at 32'h200 in the same cycle.
  - Required: memory sees 32'h100 first, then 32'h200; each port gets only its own data.
- Round-robin fairness:
  - Stimulus: both ports re-request immediately after every return, for 6 transactions.
  - Required: grant order 0,1,0,1,0,1; no port is starved.
- Back-pressure:
  - Stimulus: mem_rrdy = 0 for 5 cycles while p1 is pending.
  - Required: no mem_ren while mem_rrdy = 0; mem_ren pulses in the cycle after mem_rrdy rises; p1_rrdy stays 0 throughout.
- Request while rrdy is low:
  - Stimulus: p0 pulses ren a second time while its slot is pending.
  - Required: the pulse is ignored; exactly one memory transaction occurs for p0.
- Reset during WAIT:
  - Stimulus: assert cpu_rst while a transaction is in WAIT, then deliver mem_rvalid after reset releases.
  - Required: all outputs return to their reset values; the late mem_rvalid produces no p0_rvalid or p1_rvalid; both rrdy = 1.
